mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Moore/Mealy FSM that sequences the 32-bit shift-add multiplier datapath.
- Drives the operand/product mux selects and the shift enable, counts iterations, and presents a start/done/ack handshake to the requester.
- Sits between the requester and the datapath; the datapath's B-register LSB feeds back as the add decision.

Parameters:
- WIDTH, 32, operand width = number of add/shift iterations.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clock  in  1  system clock. Reset is Reset, synchronous, active-high; clock is Clock.
- Reset  in  1  synchronous active-high reset.
- iStart  in  1  request a multiply; sampled only in IDLE or in DONE together with iAck.
- iAck  in  1  requester has consumed the product; sampled only in DONE.
- iAbort  in  1  cancel an in-flight multiply (LOAD/ITER only).
- iB_LSB  in  1  LSB of the datapath B register.
- oB_Sel  out  1  1 = load B operand, 0 = take shifted B.
- oA_Sel  out  1  1 = load A operand, 0 = take shifted A.
- oProd_Sel  out  1  1 = clear product register, 0 = take adder-mux output.
- oAdd_Sel  out  1  1 = product += A, 0 = product holds.
- oShift_Enable  out  1  1 during iteration cycles.
- oBusy  out  1  high in LOAD and ITER.
- oDone  out  1  high in DONE; product on datapath is valid.
- oCount  out  CNT_W  current iteration index.

Behaviour:
- States: IDLE, LOAD, ITER, DONE. State and count are registered. All outputs decode state combinationally, except oAdd_Sel, which in ITER equals iB_LSB (Mealy).
- Reset, at any state including mid-operation:
  - State -> IDLE; count -> 0.
  - Outputs take IDLE values: oA_Sel=1, oB_Sel=1, oProd_Sel=0, oAdd_Sel=0, oShift_Enable=0, oBusy=0, oDone=0, oCount=0.
- IDLE:
  - Operands track the inputs (A_Sel/B_Sel=1); product holds (Prod_Sel=0, Add_Sel=0).
  - iStart=1 -> LOAD.
- LOAD (1 cycle):
  - A_Sel=1, B_Sel=1, Prod_Sel=1, Add_Sel=0, Shift_Enable=0, Busy=1; count -> 0.
  - Next state: ITER; iAbort=1 -> IDLE.
- ITER (exactly WIDTH cycles):
  - A_Sel=0, B_Sel=0, Prod_Sel=0, Shift_Enable=1, Add_Sel=iB_LSB, Busy=1.
  - count increments each cycle.
  - When count==WIDTH-1: count -> 0, next state DONE.
  - iAbort=1 -> IDLE with no oDone pulse; the partial product is left in the datapath and is undefined.
- DONE:
  - A_Sel=0, B_Sel=0, Prod_Sel=0, Add_Sel=0, Shift_Enable=0, Done=1; product holds indefinitely.
  - iAck=1 and iStart=0 -> IDLE.
  - iAck=1 and iStart=1 -> LOAD (back-to-back multiply).
  - iAck=0 -> stay in DONE; iStart is ignored.
- iStart while Busy is ignored, not queued. iAbort in IDLE or DONE is ignored.
- Latency: iStart sampled at edge 0 -> LOAD in cycle 1 -> ITER in cycles 2..WIDTH+1 -> oDone=1 from cycle WIDTH+2. For WIDTH=32, oDone rises 34 cycles after the start edge.
- Arithmetic width: the product is 2*WIDTH bits, the A operand is added zero-extended, and there is no overflow.
- The operand inputs must be stable during the LOAD cycle; they are don't-care otherwise.

Test Plan:
- Reset, then iStart with A=3, B=5 -> oBusy for 33 cycles; oDone at cycle 34; Prod=64'd15; oAdd_Sel pulses in iterations 0 and 2 only.
- A=0xFFFFFFFF, B=0xFFFFFFFF -> Prod=0xFFFFFFFE00000001; oAdd_Sel=1 on all 32 iterations.
- A=0x12345678, B=0 -> Prod=0; oAdd_Sel never asserts. Hold iAck=0 for 10 cycles -> oDone and Prod stay stable.
- In DONE, drive iAck=1 and iStart=1 with A=7, B=6 -> next cycle is LOAD with no IDLE cycle; second oDone gives Prod=42.
- Mid-operation cases:
  - iAbort at iteration 10 -> IDLE next cycle; oDone never asserts; a new iStart with A=2, B=9 gives Prod=18.
  - Reset at iteration 20 -> all outputs at reset values the cycle after; no oDone.
- iStart pulsed during ITER -> ignored; exactly one oDone occurs; the result matches the original operands.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequencer for a shift-add multiplier: drives the datapath selects and shift
// enable, counts iterations, and runs a start/done/ack handshake with the requester.
module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iAck,
  input  logic             iAbort,
  input  logic             iB_LSB,
  output logic             oB_Sel,
  output logic             oA_Sel,
  output logic             oProd_Sel,
  output logic             oAdd_Sel,
  output logic             oShift_Enable,
  output logic             oBusy,
  output logic             oDone,
  output logic [CNT_W-1:0] oCount
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] count;

  // Bit order: {a_sel, b_sel, prod_sel, shift_enable, busy, done}.
  function automatic logic [5:0] decode(input state_t s);
    case (s)
      LOAD:    return 6'b111010;
      ITER:    return 6'b000110;
      DONE:    return 6'b000001;
      default: return 6'b110000;
    endcase
  endfunction

  // NOTE: nxt gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (iStart) nxt = LOAD;
      LOAD: nxt = iAbort ? IDLE : ITER;
      ITER: begin
        if (iAbort)                  nxt = IDLE;
        else if (count == LAST_ITER) nxt = DONE;
      end
      DONE: if (iAck) nxt = iStart ? LOAD : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the
  // state register exactly as a decode of the current state would.
  // NOTE: Reset is synchronous and active-high, so it appears only inside the clocked branch.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      {oA_Sel, oB_Sel, oProd_Sel, oShift_Enable, oBusy, oDone} <= decode(IDLE);
    end else begin
      state <= nxt;
      {oA_Sel, oB_Sel, oProd_Sel, oShift_Enable, oBusy, oDone} <= decode(nxt);
      case (state)
        LOAD: count <= '0;
        ITER: begin
          if (iAbort || count == LAST_ITER) count <= '0;
          else                              count <= count + CNT_W'(1);
        end
        default: count <= count;
      endcase
    end
  end

  // Add decision follows the B-register LSB combinationally during iteration.
  assign oAdd_Sel = oShift_Enable & iB_LSB;
  assign oCount   = count;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: a bench-side shift-add datapath closes
// the loop, and a per-cycle reference model of the handshake checks every output.
module tb_mult_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             iStart = 1'b0;
  logic             iAck = 1'b0;
  logic             iAbort = 1'b0;
  logic             iB_LSB;
  logic             oB_Sel, oA_Sel, oProd_Sel, oAdd_Sel, oShift_Enable, oBusy, oDone;
  logic [CNT_W-1:0] oCount;

  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [63:0] dp_a = '0;
  logic [31:0] dp_b = '0;
  logic [63:0] dp_p = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iAck(iAck), .iAbort(iAbort),
    .iB_LSB(iB_LSB), .oB_Sel(oB_Sel), .oA_Sel(oA_Sel), .oProd_Sel(oProd_Sel),
    .oAdd_Sel(oAdd_Sel), .oShift_Enable(oShift_Enable), .oBusy(oBusy),
    .oDone(oDone), .oCount(oCount)
  );

  // Datapath the controller steers: A shifts left, B shifts right, P accumulates.
  always @(posedge Clock) begin
    if (oA_Sel) dp_a <= {32'b0, op_a};
    else if (oShift_Enable) dp_a <= dp_a << 1;
    if (oB_Sel) dp_b <= op_b;
    else if (oShift_Enable) dp_b <= dp_b >> 1;
    if (oProd_Sel) dp_p <= '0;
    else if (oAdd_Sel) dp_p <= dp_p + dp_a;
  end
  assign iB_LSB = dp_b[0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which phase of a transaction we are in and which multiplier bit is live.
  typedef enum {M_IDLE, M_LOAD, M_ITER, M_DONE} mode_t;
  mode_t       m_mode  = M_IDLE;
  int          m_i     = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_a     = '0;
  logic [31:0] m_b     = '0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_mode  <= M_IDLE;
      m_i     <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      case (m_mode)
        M_IDLE: if (iStart) begin m_mode <= M_LOAD; m_a <= op_a; m_b <= op_b; end
        M_LOAD: begin m_mode <= iAbort ? M_IDLE : M_ITER; m_i <= 0; end
        M_ITER: begin
          if (iAbort) m_mode <= M_IDLE;
          else if (m_i == WIDTH - 1) m_mode <= M_DONE;
          else m_i <= m_i + 1;
        end
        M_DONE: if (iAck) begin
          if (iStart) begin m_mode <= M_LOAD; m_a <= op_a; m_b <= op_b; end
          else m_mode <= M_IDLE;
        end
      endcase
    end
  end

  // Compare process: {A_Sel, B_Sel, Prod_Sel, Add_Sel, Shift_Enable, Busy, Done}.
  always @(negedge Clock) begin
    logic [6:0] e;
    if (m_valid && !Reset) begin
      case (m_mode)
        M_IDLE:  e = 7'b1100000;
        M_LOAD:  e = 7'b1110010;
        M_ITER:  e = {3'b000, m_b[m_i], 3'b110};
        default: e = 7'b0000001;
      endcase
      check("outputs", {57'b0, oA_Sel, oB_Sel, oProd_Sel, oAdd_Sel, oShift_Enable, oBusy, oDone},
            {57'b0, e});
      if (m_mode == M_ITER) check("count_iter", {58'b0, oCount}, 64'(m_i));
      if (m_mode == M_DONE) begin
        check("count_done", {58'b0, oCount}, 64'd0);
        check("product", dp_p, 64'(m_a) * 64'(m_b));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
    op_a = a; op_b = b; iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  // Counts samples from the current cycle until oDone, tallying busy and add cycles.
  task automatic wait_done(output int lat, output int busy_n, output int add_n);
    bit seen = 1'b0;
    lat = 0; busy_n = 0; add_n = 0;
    for (int n = 0; n < 200; n++) begin
      lat++;
      busy_n += int'(oBusy);
      add_n  += int'(oAdd_Sel);
      if (oDone) begin seen = 1'b1; break; end
      tick();
    end
    check("done_seen", {63'b0, seen}, 64'd1);
  endtask

  task automatic ack_idle();
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
  endtask

  task automatic goto_iter(input int it);
    bit found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (oShift_Enable && int'(oCount) == it) begin found = 1'b1; break; end
      tick();
    end
    check("reach_iter", {63'b0, found}, 64'd1);
  endtask

  task automatic count_dones(input int cycles, output int dones);
    dones = 0;
    repeat (cycles) begin tick(); dones += int'(oDone); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bz, ad, dones, abort_at;
    bit aborted, b2b;

    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    check("reset_outs", {57'b0, oA_Sel, oB_Sel, oProd_Sel, oAdd_Sel, oShift_Enable, oBusy, oDone},
          64'b1100000);
    check("reset_count", {58'b0, oCount}, 64'd0);

    // 3 x 5: adds on iterations 0 and 2 only.
    start_mult(32'd3, 32'd5);
    wait_done(lat, bz, ad);
    check("t1_latency", 64'(lat), 64'd34);
    check("t1_busy_cycles", 64'(bz), 64'd33);
    check("t1_add_pulses", 64'(ad), 64'd2);
    check("t1_product", dp_p, 64'd15);
    ack_idle();
    check("t1_idle_after_ack", {62'b0, oBusy, oDone}, 64'd0);

    start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bz, ad);
    check("t2_add_pulses", 64'(ad), 64'd32);
    check("t2_product", dp_p, 64'hFFFF_FFFE_0000_0001);
    ack_idle();

    // B = 0; then hold in DONE with no ack while start and abort are ignored.
    start_mult(32'h1234_5678, 32'd0);
    wait_done(lat, bz, ad);
    check("t3_add_pulses", 64'(ad), 64'd0);
    iStart = 1'b1; iAbort = 1'b1;
    repeat (10) tick();
    iStart = 1'b0; iAbort = 1'b0;
    check("t3_done_held", {63'b0, oDone}, 64'd1);
    check("t3_product_held", dp_p, 64'd0);

    // Back-to-back: ack and start together go straight to LOAD.
    op_a = 32'd7; op_b = 32'd6; iAck = 1'b1; iStart = 1'b1;
    tick();
    iAck = 1'b0; iStart = 1'b0;
    check("t4_b2b_load", {61'b0, oBusy, oProd_Sel, oDone}, 64'b110);
    wait_done(lat, bz, ad);
    check("t4_product", dp_p, 64'd42);
    ack_idle();

    // Abort at iteration 10, then a clean multiply.
    start_mult(32'd1234, 32'd5678);
    goto_iter(10);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    check("t5_abort_idle", {61'b0, oBusy, oDone, oShift_Enable}, 64'd0);
    count_dones(40, dones);
    check("t5_no_done", 64'(dones), 64'd0);
    start_mult(32'd2, 32'd9);
    wait_done(lat, bz, ad);
    check("t5_product", dp_p, 64'd18);
    ack_idle();

    // Reset at iteration 20.
    start_mult(32'hDEAD_BEEF, 32'h0000_1357);
    goto_iter(20);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t6_reset_outs", {57'b0, oA_Sel, oB_Sel, oProd_Sel, oAdd_Sel, oShift_Enable, oBusy, oDone},
          64'b1100000);
    check("t6_reset_count", {58'b0, oCount}, 64'd0);
    count_dones(40, dones);
    check("t6_no_done", 64'(dones), 64'd0);

    // Start pulsed mid-iteration with different operands is ignored.
    start_mult(32'd11, 32'd13);
    goto_iter(5);
    op_a = 32'd99; op_b = 32'd99; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    wait_done(lat, bz, ad);
    check("t7_product", dp_p, 64'd143);
    ack_idle();
    count_dones(40, dones);
    check("t7_single_done", 64'(dones), 64'd0);

    // Random transactions: aborts, stray starts, ack delays, back-to-back starts.
    b2b = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (!b2b) begin
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        start_mult(a, b);
      end
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
      aborted = 1'b0;
      for (int n = 0; n < 60; n++) begin
        if (oDone) break;
        if (oShift_Enable && int'(oCount) == abort_at) begin
          iAbort = 1'b1;
          tick();
          iAbort = 1'b0;
          aborted = 1'b1;
          break;
        end
        iStart = ($urandom_range(0, 7) == 0);
        tick();
        iStart = 1'b0;
      end
      check("rand_end", {63'b0, oDone | aborted}, 64'd1);
      if (!aborted) begin
        repeat ($urandom_range(0, 4)) tick();
        b2b = 1'($urandom_range(0, 1));
        if (b2b) begin op_a = $urandom; op_b = $urandom; iStart = 1'b1; end
        iAck = 1'b1;
        tick();
        iAck = 1'b0; iStart = 1'b0;
      end else begin
        b2b = 1'b0;
      end
    end
    if (b2b) begin
      wait_done(lat, bz, ad);
      ack_idle();
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
